mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Responder side of the instruction-fetch memory protocol, and owner of the byte-wide RAM/IO port. Serves 32-bit instruction-fill requests from the icache and 1/2/4-byte load/store requests from the load-store buffer (LSB), serialising each request into byte accesses. Returns read data as one word with a single-cycle valid pulse, or pulses done for stores. Sits between icache/LSB and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
IO_HI_BITS, 2'b11, value of addr[17:16] that marks the IO region (store stall applies).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; low freezes the block
clear  in  1  mispredict flush; aborts in-flight fetch/load
IC_addr  in  32  icache fill address (word aligned)
IC_addr_sgn  in  1  icache request (level, held until served)
IC_val  out  32  fetched instruction, little-endian
IC_val_sgn  out  1  one-cycle valid pulse for IC_val
LSB_addr  in  32  load/store byte address
LSB_sgn  in  1  LSB request (level)
LSB_wr  in  1  1 = store, 0 = load
LSB_len  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
LSB_data  in  32  store data, low bytes used
LSB_val  out  32  load data, zero-extended
LSB_done  out  1  one-cycle pulse: load data valid or store complete
mem_din  in  8  RAM read byte (one-cycle read latency)
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  IO output buffer full

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; IC_val, LSB_val, mem_a, mem_dout = 0; IC_val_sgn, LSB_done, mem_wr = 0; byte counters = 0.
- States: IDLE, FETCH, LOAD, STORE.
- IDLE accept rules:
  - No request is accepted in any cycle where IC_val_sgn or LSB_done is high.
  - If both ports request, LSB wins.
  - LSB_wr selects STORE or LOAD. Otherwise IC_addr_sgn selects FETCH, with N = 4.
  - Address and data are latched on the accepting edge E0.
- Read (FETCH/LOAD, N bytes):
  - Cycles after E0..E(N-1) drive mem_a = addr+i, mem_wr = 0.
  - mem_din holds byte i in the cycle after address i is driven.
  - Byte i is placed at bits [8i+7:8i].
  - The last byte is captured at E(N+1); the valid/done pulse is high for exactly the cycle after E(N+1). State returns to IDLE at that edge.
  - A 4-byte fetch gives IC_val_sgn high 6 cycles after the request is first sampled.
- Store:
  - Cycles after E0..E(N-1) drive mem_wr = 1, mem_a = addr+i, mem_dout = data byte i.
  - LSB_done is high for the cycle after EN; return to IDLE.
- IO stall: during STORE, if addr[17:16] == IO_HI_BITS and io_buffer_full is high, drive mem_wr = 0 that cycle and do not advance the counter.
- rdy low:
  - All state, counters and outputs hold; mem_wr forced 0; mem_din ignored.
  - On rdy return, a read resumes by re-issuing the address of the first uncaptured byte (one bubble).
- clear:
  - Aborts FETCH/LOAD next edge: go to IDLE with no valid pulse, and clear any pending IC_val_sgn.
  - A STORE in progress is committed and runs to completion; clear is ignored for it.
  - clear in IDLE blocks acceptance that cycle.
- Valid and done outputs are strictly one-cycle pulses. Data outputs hold until the next completion.
- Address increment wraps modulo 2^32.
- IDLE: mem_wr = 0; mem_a holds its last value.

Decomposition:
- defines.v holds:
  - state encodings (MC_IDLE/FETCH/LOAD/STORE)
  - LEN encodings
  - IO_HI_BITS and the IO address field range [17:16]
- Single module. No sub-module is needed; byte assembly and the counter live inline.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,00,00; IC_addr = 0x100 held -> IC_val = 0x00000513, IC_val_sgn high exactly 1 cycle, 6 cycles after request; mem_wr never 1.
- Load: LSB_len = 1, addr 0x201, RAM = AB,CD -> LSB_val = 0x0000CDAB; LSB_done 1-cycle pulse.
- Store: LSB_len = 2, addr 0x300, data 0x11223344 -> mem_wr high 4 consecutive cycles writing 44,33,22,11 to 0x300..0x303; LSB_done the next cycle.
- Arbitration: IC and LSB load requests asserted the same cycle -> LSB served first; icache served next after the gap cycle; no request accepted during a pulse cycle.
- IO stall: store 1 byte to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr = 0 for those cycles, then one write of the byte, then LSB_done.
- Flush/rdy:
  - clear mid-FETCH -> no IC_val_sgn; returns to IDLE.
  - clear mid-STORE -> all bytes still written.
  - rdy low for 2 cycles mid-fetch -> correct word, delayed by stall + 1.
  - rst_n low mid-op -> outputs zero immediately.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_FETCH = 2'd1,
    MC_LOAD  = 2'd2,
    MC_STORE = 2'd3
  } mc_state_e;

  typedef logic [1:0] lsb_len_t;

  localparam lsb_len_t LEN_BYTE = 2'd0;
  localparam lsb_len_t LEN_HALF = 2'd1;
  localparam lsb_len_t LEN_WORD = 2'd2;

  localparam logic [1:0] IO_HI_BITS_DEF = 2'b11;
  localparam int IO_FIELD_HI = 17;
  localparam int IO_FIELD_LO = 16;

  function automatic logic [2:0] len_bytes(input lsb_len_t len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Icache, load-store buffer and byte-wide RAM signals seen by mem_ctrl.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic [31:0] IC_addr;
  logic        IC_addr_sgn;
  logic [31:0] IC_val;
  logic        IC_val_sgn;
  logic [31:0] LSB_addr;
  logic        LSB_sgn;
  logic        LSB_wr;
  lsb_len_t    LSB_len;
  logic [31:0] LSB_data;
  logic [31:0] LSB_val;
  logic        LSB_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  IC_addr, IC_addr_sgn, LSB_addr, LSB_sgn, LSB_wr, LSB_len, LSB_data,
           mem_din, io_buffer_full,
    output IC_val, IC_val_sgn, LSB_val, LSB_done, mem_dout, mem_a, mem_wr
  );

  modport master (
    output IC_addr, IC_addr_sgn, LSB_addr, LSB_sgn, LSB_wr, LSB_len, LSB_data,
           mem_din, io_buffer_full,
    input  IC_val, IC_val_sgn, LSB_val, LSB_done, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises icache fills and LSB loads/stores onto the byte-wide RAM/IO port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI_BITS = IO_HI_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       clear,
  mem_ctrl_if.slave  mif
);

  mc_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  a_cnt_q, a_cnt_d;
  logic [2:0]  r_cnt_q, r_cnt_d;
  logic        addr_live_q, addr_live_d;
  logic        din_live_q, din_live_d;
  logic        stall_q, stall_d;
  logic [31:0] word_q, word_d;
  logic [31:0] ic_val_q, ic_val_d;
  logic        ic_val_sgn_q, ic_val_sgn_d;
  logic [31:0] lsb_val_q, lsb_val_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;

  logic        io_stall;
  logic        wr_fire;
  logic [31:0] word_cap;
  logic [1:0]  nb_idx;
  logic [7:0]  next_byte;

  assign io_stall  = (state_q == MC_STORE) && mif.io_buffer_full &&
                     (mem_a_q[IO_FIELD_HI:IO_FIELD_LO] == IO_HI_BITS);
  assign wr_fire   = (state_q == MC_STORE) && rdy && !io_stall;
  assign nb_idx    = r_cnt_q[1:0] + 2'd1;
  assign next_byte = data_q[{nb_idx, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    n_d          = n_q;
    a_cnt_d      = a_cnt_q;
    r_cnt_d      = r_cnt_q;
    addr_live_d  = addr_live_q;
    din_live_d   = din_live_q;
    stall_d      = stall_q;
    word_d       = word_q;
    ic_val_d     = ic_val_q;
    ic_val_sgn_d = ic_val_sgn_q;
    lsb_val_d    = lsb_val_q;
    lsb_done_d   = lsb_done_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    word_cap     = word_q;
    word_cap[{r_cnt_q[1:0], 3'b000} +: 8] = mif.mem_din;

    if (!rdy) begin
      // Remember the freeze so a read re-issues its first uncaptured byte.
      stall_d = 1'b1;
    end else begin
      stall_d      = 1'b0;
      ic_val_sgn_d = 1'b0;
      lsb_done_d   = 1'b0;
      case (state_q)
        MC_IDLE: begin
          if (!clear && !ic_val_sgn_q && !lsb_done_q && (mif.LSB_sgn || mif.IC_addr_sgn)) begin
            a_cnt_d    = 3'd1;
            r_cnt_d    = 3'd0;
            din_live_d = 1'b0;
            word_d     = '0;
            if (mif.LSB_sgn) begin
              addr_d      = mif.LSB_addr;
              data_d      = mif.LSB_data;
              n_d         = len_bytes(mif.LSB_len);
              mem_a_d     = mif.LSB_addr;
              mem_dout_d  = mif.LSB_data[7:0];
              addr_live_d = !mif.LSB_wr;
              state_d     = mif.LSB_wr ? MC_STORE : MC_LOAD;
            end else begin
              addr_d      = mif.IC_addr;
              n_d         = 3'd4;
              mem_a_d     = mif.IC_addr;
              addr_live_d = 1'b1;
              state_d     = MC_FETCH;
            end
          end
        end
        MC_FETCH, MC_LOAD: begin
          if (clear) begin
            state_d     = MC_IDLE;
            addr_live_d = 1'b0;
            din_live_d  = 1'b0;
          end else if (stall_q) begin
            mem_a_d     = addr_q + {29'd0, r_cnt_q};
            a_cnt_d     = r_cnt_q + 3'd1;
            addr_live_d = 1'b1;
            din_live_d  = 1'b0;
          end else begin
            din_live_d = addr_live_q;
            if (a_cnt_q < n_q) begin
              mem_a_d     = addr_q + {29'd0, a_cnt_q};
              a_cnt_d     = a_cnt_q + 3'd1;
              addr_live_d = 1'b1;
            end else begin
              addr_live_d = 1'b0;
            end
            if (din_live_q) begin
              word_d  = word_cap;
              r_cnt_d = r_cnt_q + 3'd1;
              if (r_cnt_q == n_q - 3'd1) begin
                state_d     = MC_IDLE;
                addr_live_d = 1'b0;
                din_live_d  = 1'b0;
                if (state_q == MC_FETCH) begin
                  ic_val_d     = word_cap;
                  ic_val_sgn_d = 1'b1;
                end else begin
                  lsb_val_d  = word_cap;
                  lsb_done_d = 1'b1;
                end
              end
            end
          end
        end
        MC_STORE: begin
          // Stores are committed once accepted, so clear is not consulted here.
          if (wr_fire) begin
            if (r_cnt_q == n_q - 3'd1) begin
              state_d    = MC_IDLE;
              lsb_done_d = 1'b1;
            end else begin
              r_cnt_d    = r_cnt_q + 3'd1;
              mem_a_d    = mem_a_q + 32'd1;
              mem_dout_d = next_byte;
            end
          end
        end
        default: state_d = MC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MC_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      n_q          <= '0;
      a_cnt_q      <= '0;
      r_cnt_q      <= '0;
      addr_live_q  <= 1'b0;
      din_live_q   <= 1'b0;
      stall_q      <= 1'b0;
      word_q       <= '0;
      ic_val_q     <= '0;
      ic_val_sgn_q <= 1'b0;
      lsb_val_q    <= '0;
      lsb_done_q   <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      n_q          <= n_d;
      a_cnt_q      <= a_cnt_d;
      r_cnt_q      <= r_cnt_d;
      addr_live_q  <= addr_live_d;
      din_live_q   <= din_live_d;
      stall_q      <= stall_d;
      word_q       <= word_d;
      ic_val_q     <= ic_val_d;
      ic_val_sgn_q <= ic_val_sgn_d;
      lsb_val_q    <= lsb_val_d;
      lsb_done_q   <= lsb_done_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
    end
  end

  assign mif.IC_val     = ic_val_q;
  assign mif.IC_val_sgn = ic_val_sgn_q;
  assign mif.LSB_val    = lsb_val_q;
  assign mif.LSB_done   = lsb_done_q;
  assign mif.mem_a      = mem_a_q;
  assign mif.mem_dout   = mem_dout_q;
  assign mif.mem_wr     = wr_fire;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, load, store, arbitration, IO stall, clear, rdy and reset.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n, rdy, clear;
  mem_ctrl_if mif ();

  mem_ctrl #(.IO_HI_BITS(2'b11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .clear (clear),
    .mif   (mif)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency; writes are only logged.
  logic [7:0]  ram [0:4095];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  always @(posedge clk) begin
    mif.mem_din <= ram[mif.mem_a[11:0]];
    if (mif.mem_wr) begin
      wlog_a.push_back(mif.mem_a);
      wlog_d.push_back(mif.mem_dout);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int t_ic, t_lsb, n_ic, n_lsb;
  logic [63:0] wmask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Runs ncyc cycles after the request cycle, applying io/rdy/clear per cycle
  // and recording pulse timing, pulse widths and which cycles wrote.
  task automatic run(input int ncyc, input int io_cyc, input int rlo_from,
                     input int rlo_n, input int clr_at);
    t_ic = -1; t_lsb = -1; n_ic = 0; n_lsb = 0; wmask = '0;
    wlog_a.delete(); wlog_d.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      mif.io_buffer_full = (c <= io_cyc);
      rdy   = !(c >= rlo_from && c < rlo_from + rlo_n);
      clear = (c == clr_at);
      if (c == clr_at) begin
        mif.IC_addr_sgn = 1'b0;
        mif.LSB_sgn     = 1'b0;
      end
      #1;
      if (mif.mem_wr) wmask[c] = 1'b1;
      if (mif.IC_val_sgn) begin
        n_ic++;
        if (t_ic < 0) t_ic = c;
        mif.IC_addr_sgn = 1'b0;
      end
      if (mif.LSB_done) begin
        n_lsb++;
        if (t_lsb < 0) t_lsb = c;
        mif.LSB_sgn = 1'b0;
      end
    end
    mif.io_buffer_full = 1'b0;
    rdy = 1'b1;
    clear = 1'b0;
  endtask

  task automatic lsb_req(input logic wr, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] d);
    mif.LSB_sgn  = 1'b1;
    mif.LSB_wr   = wr;
    mif.LSB_len  = len;
    mif.LSB_addr = a;
    mif.LSB_data = d;
  endtask

  task automatic ic_req(input logic [31:0] a);
    mif.IC_addr_sgn = 1'b1;
    mif.IC_addr     = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h104] = 8'h93; ram[12'h105] = 8'h00; ram[12'h106] = 8'h10; ram[12'h107] = 8'h00;
    ram[12'h201] = 8'hAB; ram[12'h202] = 8'hCD;

    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0;
    mif.IC_addr = '0; mif.IC_addr_sgn = 1'b0;
    mif.LSB_addr = '0; mif.LSB_sgn = 1'b0; mif.LSB_wr = 1'b0;
    mif.LSB_len = 2'd0; mif.LSB_data = '0; mif.io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ic_val",   mif.IC_val, 32'h0);
    chk("rst_ic_sgn",   {31'd0, mif.IC_val_sgn}, 32'h0);
    chk("rst_lsb_val",  mif.LSB_val, 32'h0);
    chk("rst_lsb_done", {31'd0, mif.LSB_done}, 32'h0);
    chk("rst_mem_a",    mif.mem_a, 32'h0);
    chk("rst_mem_out",  {24'd0, mif.mem_dout}, 32'h0);
    chk("rst_mem_wr",   {31'd0, mif.mem_wr}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch 0x100
    ic_req(32'h100);
    run(10, 0, 0, 0, 0);
    chk("fetch_lat",   t_ic, 6);
    chk("fetch_val",   mif.IC_val, 32'h0000_0513);
    chk("fetch_width", n_ic, 1);
    chk("fetch_nowr",  wmask[31:0], 32'h0);

    // Halfword load 0x201
    lsb_req(1'b0, 2'd1, 32'h201, 32'h0);
    run(8, 0, 0, 0, 0);
    chk("load_lat",   t_lsb, 4);
    chk("load_val",   mif.LSB_val, 32'h0000_CDAB);
    chk("load_width", n_lsb, 1);

    // Word store 0x300
    lsb_req(1'b1, 2'd2, 32'h300, 32'h1122_3344);
    run(8, 0, 0, 0, 0);
    chk("store_wmask", wmask[31:0], 32'h0000_001E);
    chk("store_done",  t_lsb, 5);
    chk("store_nwr",   wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      chk("store_a0", wlog_a[0], 32'h300);
      chk("store_d0", {24'd0, wlog_d[0]}, 32'h44);
      chk("store_d1", {24'd0, wlog_d[1]}, 32'h33);
      chk("store_d2", {24'd0, wlog_d[2]}, 32'h22);
      chk("store_a3", wlog_a[3], 32'h303);
      chk("store_d3", {24'd0, wlog_d[3]}, 32'h11);
    end

    // Simultaneous IC fetch and LSB byte load: LSB first
    ic_req(32'h104);
    lsb_req(1'b0, 2'd0, 32'h201, 32'h0);
    run(14, 0, 0, 0, 0);
    chk("arb_lsb_lat", t_lsb, 3);
    chk("arb_lsb_val", mif.LSB_val, 32'h0000_00AB);
    chk("arb_ic_lat",  t_ic, 10);
    chk("arb_ic_val",  mif.IC_val, 32'h0010_0093);
    chk("arb_pulses",  n_ic + n_lsb, 2);

    // Byte store to IO region with buffer full for three cycles
    lsb_req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
    run(8, 3, 0, 0, 0);
    chk("io_wmask", wmask[31:0], 32'h0000_0010);
    chk("io_done",  t_lsb, 5);
    chk("io_nwr",   wlog_a.size(), 1);
    if (wlog_a.size() == 1) begin
      chk("io_a", wlog_a[0], 32'h0003_0000);
      chk("io_d", {24'd0, wlog_d[0]}, 32'h5A);
    end

    // Clear mid-fetch
    ic_req(32'h100);
    run(12, 0, 0, 0, 3);
    chk("clrf_pulse", n_ic, 0);
    chk("clrf_val",   mif.IC_val, 32'h0010_0093);
    chk("clrf_mem_a", mif.mem_a, 32'h102);

    // Clear mid-store
    lsb_req(1'b1, 2'd2, 32'h300, 32'hA1B2_C3D4);
    run(8, 0, 0, 0, 2);
    chk("clrs_wmask", wmask[31:0], 32'h0000_001E);
    chk("clrs_done",  t_lsb, 5);
    chk("clrs_nwr",   wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      chk("clrs_d0", {24'd0, wlog_d[0]}, 32'hD4);
      chk("clrs_d3", {24'd0, wlog_d[3]}, 32'hA1);
    end

    // rdy low for two cycles right after acceptance
    ic_req(32'h100);
    run(14, 0, 1, 2, 0);
    chk("rdy_lat",   t_ic, 9);
    chk("rdy_val",   mif.IC_val, 32'h0000_0513);
    chk("rdy_width", n_ic, 1);

    // Asynchronous reset in the middle of a store
    lsb_req(1'b1, 2'd2, 32'h300, 32'h5566_7788);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstm_pre_wr", {31'd0, mif.mem_wr}, 32'h1);
    mif.LSB_sgn = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstm_wr",     {31'd0, mif.mem_wr}, 32'h0);
    chk("rstm_mem_a",  mif.mem_a, 32'h0);
    chk("rstm_dout",   {24'd0, mif.mem_dout}, 32'h0);
    chk("rstm_ic_val", mif.IC_val, 32'h0);
    chk("rstm_lsbval", mif.LSB_val, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
